// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared opcode, ALU and FSM state encodings for vector_exec_seq
package vec_pkg;

  typedef enum logic [1:0] {
    OP_SCALAR = 2'b00,
    OP_VV     = 2'b01,
    OP_VS     = 2'b10,
    OP_RSVD   = 2'b11
  } op_type_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } exec_state_e;

  localparam logic [1:0] FLAGS_NONE = 2'b00;
  localparam logic [1:0] FLAGS_ZERO = 2'b01;

endpackage

// File: rtl/vec_lane_alu.sv
// rtl/vec_lane_alu.sv - combinational N-bit lane ALU, optional signed saturation on add/sub
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int N   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] res_o
);

  if (SAT) begin : g_sat
    logic [N:0] ext_sum;

    // Signed add/sub one bit wider; differing top two bits mean overflow, clamp by sign
    always_comb begin
      ext_sum = '0;
      res_o   = '0;
      case (op_i)
        ALU_ADD, ALU_SUB: begin
          if (op_i == ALU_ADD) ext_sum = {a_i[N-1], a_i} + {b_i[N-1], b_i};
          else                 ext_sum = {a_i[N-1], a_i} - {b_i[N-1], b_i};
          if (ext_sum[N] != ext_sum[N-1])
            res_o = ext_sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          else
            res_o = ext_sum[N-1:0];
        end
        ALU_AND: res_o = a_i & b_i;
        default: res_o = a_i | b_i;
      endcase
    end
  end else begin : g_wrap
    // Plain modulo-2^N arithmetic and bitwise ops
    always_comb begin
      res_o = '0;
      case (op_i)
        ALU_ADD: res_o = a_i + b_i;
        ALU_SUB: res_o = a_i - b_i;
        ALU_AND: res_o = a_i & b_i;
        default: res_o = a_i | b_i;
      endcase
    end
  end

endmodule

// File: rtl/vector_exec_seq.sv
// rtl/vector_exec_seq.sv - scalar/vector ALU sequencer; define VEC_EXEC_SAT_EN for saturating vector lanes
module vector_exec_seq
  import vec_pkg::*;
#(
  parameter int N     = 32,
  parameter int V     = 8,
  parameter int LANES = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [1:0]     op_type_i,
  input  logic [1:0]     alu_ctrl_i,
  input  logic [V*N-1:0] vec_a_i,
  input  logic [V*N-1:0] vec_b_i,
  input  logic [N-1:0]   scalar_a_i,
  input  logic [N-1:0]   scalar_b_i,
  input  logic [4:0]     a3_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [V*N-1:0] result_v_o,
  output logic [N-1:0]   result_s_o,
  output logic [1:0]     flags_o,
  output logic [4:0]     a3_o,
  output logic           busy_o
);

  localparam int BEATS = V / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef VEC_EXEC_SAT_EN
  localparam bit LANE_SAT = 1'b1;
`else
  localparam bit LANE_SAT = 1'b0;
`endif

  exec_state_e    state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  op_type_e       op_q, op_d;
  alu_op_e        alu_q, alu_d;
  logic [4:0]     a3_q, a3_d;
  logic [V*N-1:0] vec_a_q, vec_a_d, vec_b_q, vec_b_d;
  logic [N-1:0]   sb_q, sb_d;
  logic [V*N-1:0] res_v_q, res_v_d;
  logic [N-1:0]   res_s_q, res_s_d;
  logic [1:0]     flags_q, flags_d;

  logic [N-1:0]   lane_a [LANES];
  logic [N-1:0]   lane_b [LANES];
  logic [N-1:0]   lane_r [LANES];
  logic [N-1:0]   scalar_r;

  // Select the slice of the captured vectors handled in the current beat
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = vec_a_q[(int'(beat_q) * LANES + l) * N +: N];
      lane_b[l] = (op_q == OP_VS) ? sb_q : vec_b_q[(int'(beat_q) * LANES + l) * N +: N];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_lane_alu #(.N(N), .SAT(LANE_SAT)) u_lane (
      .a_i  (lane_a[g]),
      .b_i  (lane_b[g]),
      .op_i (alu_q),
      .res_o(lane_r[g])
    );
  end

  // Scalar result is produced straight from the inputs on the accept edge, always wrapping
  vec_lane_alu #(.N(N), .SAT(1'b0)) u_scalar (
    .a_i  (scalar_a_i),
    .b_i  (scalar_b_i),
    .op_i (alu_op_e'(alu_ctrl_i)),
    .res_o(scalar_r)
  );

  // Next-state: accept in IDLE, stream beats in RUN, hold in DONE; flush overrides everything
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    alu_d   = alu_q;
    a3_d    = a3_q;
    vec_a_d = vec_a_q;
    vec_b_d = vec_b_q;
    sb_d    = sb_q;
    res_v_d = res_v_q;
    res_s_d = res_s_q;
    flags_d = flags_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_d    = op_type_e'(op_type_i);
            alu_d   = alu_op_e'(alu_ctrl_i);
            a3_d    = a3_i;
            vec_a_d = vec_a_i;
            vec_b_d = vec_b_i;
            sb_d    = scalar_b_i;
            beat_d  = '0;
            case (op_type_e'(op_type_i))
              OP_SCALAR: begin
                res_s_d = scalar_r;
                flags_d = {scalar_r[N-1], scalar_r == '0};
                state_d = ST_DONE;
              end
              OP_RSVD: begin
                res_s_d = '0;
                flags_d = FLAGS_ZERO;
                state_d = ST_DONE;
              end
              default: begin
                flags_d = FLAGS_NONE;
                state_d = ST_RUN;
              end
            endcase
          end
        end
        ST_RUN: begin
          for (int l = 0; l < LANES; l++)
            res_v_d[(int'(beat_q) * LANES + l) * N +: N] = lane_r[l];
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_DONE: begin
          if (ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      op_q    <= OP_SCALAR;
      alu_q   <= ALU_ADD;
      a3_q    <= '0;
      vec_a_q <= '0;
      vec_b_q <= '0;
      sb_q    <= '0;
      res_v_q <= '0;
      res_s_q <= '0;
      flags_q <= FLAGS_NONE;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      a3_q    <= a3_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      sb_q    <= sb_d;
      res_v_q <= res_v_d;
      res_s_q <= res_s_d;
      flags_q <= flags_d;
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign busy_o     = (state_q != ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign result_v_o = res_v_q;
  assign result_s_o = res_s_q;
  assign flags_o    = flags_q;
  assign a3_o       = a3_q;

endmodule

// File: tb/tb_vector_exec_seq.sv
// tb/tb_vector_exec_seq.sv - directed plus randomized checks of vector_exec_seq against a reference model
module tb_vector_exec_seq;

  localparam int N     = 32;
  localparam int V     = 8;
  localparam int LANES = 4;
  localparam int W     = V * N;

`ifdef VEC_EXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           flush_i = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [1:0]     op_type_i = '0;
  logic [1:0]     alu_ctrl_i = '0;
  logic [W-1:0]   vec_a_i = '0;
  logic [W-1:0]   vec_b_i = '0;
  logic [N-1:0]   scalar_a_i = '0;
  logic [N-1:0]   scalar_b_i = '0;
  logic [4:0]     a3_i = '0;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [W-1:0]   result_v_o;
  logic [N-1:0]   result_s_o;
  logic [1:0]     flags_o;
  logic [4:0]     a3_o;
  logic           busy_o;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_v;
  logic [N-1:0] exp_s;
  logic [1:0]   exp_f;
  logic [4:0]   exp_a3;
  bit           v_known;

  vector_exec_seq #(.N(N), .V(V), .LANES(LANES)) dut (
    .CLK(CLK), .RST(RST), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_type_i(op_type_i), .alu_ctrl_i(alu_ctrl_i), .vec_a_i(vec_a_i), .vec_b_i(vec_b_i),
    .scalar_a_i(scalar_a_i), .scalar_b_i(scalar_b_i), .a3_i(a3_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_v_o(result_v_o), .result_s_o(result_s_o), .flags_o(flags_o),
    .a3_o(a3_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Element operation from arithmetic on integers; saturation is a clamp of the true signed value
  function automatic logic [N-1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input int op, input bit sat);
    longint x, y, r, hi, lo;
    logic [63:0] bits;
    x  = longint'($signed(a));
    y  = longint'($signed(b));
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -(longint'(1) <<< (N - 1));
    case (op)
      0: r = x + y;
      1: r = x - y;
      2: return a & b;
      default: return a | b;
    endcase
    if (sat && r > hi) r = hi;
    if (sat && r < lo) r = lo;
    bits = r;
    return bits[N-1:0];
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < V; i++) begin
      vec_a_i[i*N +: N] = $urandom;
      vec_b_i[i*N +: N] = $urandom;
    end
    scalar_a_i = $urandom;
    scalar_b_i = $urandom;
    op_type_i  = 2'($urandom);
    alu_ctrl_i = 2'($urandom);
    a3_i       = 5'($urandom);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".result_s"}, result_s_o, exp_s);
    chk({tag, ".flags"}, flags_o, exp_f);
    chk({tag, ".a3"}, a3_o, exp_a3);
    if (v_known) chk({tag, ".result_v"}, result_v_o, exp_v);
  endtask

  // One complete operation: issue, scramble inputs, measure latency, hold in DONE, release
  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] alu,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [N-1:0] sa, input logic [N-1:0] sb,
                        input logic [4:0] tag5, input int hold);
    int lat, exp_lat;
    logic [N-1:0] eb;
    exp_a3 = tag5;
    if (op == 2'b00) begin
      exp_s = ref_alu(sa, sb, int'(alu), 1'b0);
      exp_f = {exp_s[N-1], exp_s == '0};
      exp_lat = 1;
    end else if (op == 2'b11) begin
      exp_s = '0;
      exp_f = 2'b01;
      exp_lat = 1;
    end else begin
      for (int i = 0; i < V; i++) begin
        eb = (op == 2'b10) ? sb : vb[i*N +: N];
        exp_v[i*N +: N] = ref_alu(va[i*N +: N], eb, int'(alu), SAT);
      end
      exp_f = 2'b00;
      v_known = 1'b1;
      exp_lat = V / LANES + 1;
    end
    chk({tag, ".ready_before"}, ready_o, 1'b1);
    op_type_i = op; alu_ctrl_i = alu; vec_a_i = va; vec_b_i = vb;
    scalar_a_i = sa; scalar_b_i = sb; a3_i = tag5; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    rand_inputs();
    lat = 1;
    while (valid_o !== 1'b1 && lat < 40) begin
      tick();
      rand_inputs();
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, ".valid_held"}, valid_o, 1'b1);
      chk({tag, ".ready_held"}, ready_o, 1'b0);
      chk_outputs(tag);
      if (h < hold) begin
        valid_i = 1'($urandom);
        tick();
        rand_inputs();
      end
    end
    ready_i = 1'b1;
    valid_i = 1'b1;
    tick();
    ready_i = 1'b0;
    valid_i = 1'b0;
    chk({tag, ".no_accept_on_release"}, busy_o, 1'b0);
    chk({tag, ".valid_after_release"}, valid_o, 1'b0);
    chk_outputs({tag, ".after"});
  endtask

  initial begin : stim
    logic [W-1:0] va, vb;
    logic [W-1:0] ovf;
    logic [N-1:0] word;

    // Reset state
    RST = 1'b0;
    valid_i = 1'b1;
    tick();
    tick();
    valid_i = 1'b0;
    exp_v = '0; exp_s = '0; exp_f = 2'b00; exp_a3 = '0; v_known = 1'b1;
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.busy", busy_o, 1'b0);
    chk_outputs("rst");
    RST = 1'b1;
    tick();
    chk("rst.ready", ready_o, 1'b1);

    // Scalar sub 5-5
    run_op("scalar_sub", 2'b00, 2'b01, '0, '0, 32'd5, 32'd5, 5'd19, 2);

    // Vector-vector add A[i]=i, B[i]=10
    for (int i = 0; i < V; i++) begin
      va[i*N +: N] = N'(i);
      vb[i*N +: N] = N'(10);
    end
    run_op("vv_add", 2'b01, 2'b00, va, vb, '0, '0, 5'd7, 0);

    // Vector-scalar and, held 5 cycles in DONE
    for (int i = 0; i < V; i++) va[i*N +: N] = 32'hFF;
    run_op("vs_and", 2'b10, 2'b10, va, '1, '0, 32'h0F, 5'd3, 5);

    // Overflow boundary
    for (int i = 0; i < V; i++) begin
      va[i*N +: N] = 32'h7FFFFFFF;
      vb[i*N +: N] = 32'h1;
    end
    run_op("vv_ovf", 2'b01, 2'b00, va, vb, '0, '0, 5'd30, 0);
    ovf = result_v_o;
    word = ovf[3*N +: N];
    chk("vv_ovf.elem3", word, SAT ? 32'h7FFFFFFF : 32'h80000000);

    // Reserved opcode
    run_op("rsvd", 2'b11, 2'b00, '0, '0, 32'h1234, 32'h1, 5'd12, 1);

    // Flush in RUN beat 1
    op_type_i = 2'b01; alu_ctrl_i = 2'b00; valid_i = 1'b1; a3_i = 5'd9;
    tick();
    valid_i = 1'b0;
    tick();
    chk("flush.busy_before", busy_o, 1'b1);
    flush_i = 1'b1;
    ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b0;
    chk("flush.busy", busy_o, 1'b0);
    chk("flush.ready", ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("flush.valid_low", valid_o, 1'b0);
      tick();
    end
    v_known = 1'b0;
    run_op("post_flush_scalar", 2'b00, 2'b00, '0, '0, 32'hFFFF_FFFF, 32'h2, 5'd21, 0);

    // Flush beats valid_i on the same edge
    valid_i = 1'b1;
    op_type_i = 2'b00;
    flush_i = 1'b1;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_vs_valid.busy", busy_o, 1'b0);

    // Randomized operations with boundary operands mixed in
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < V; i++) begin
        case ($urandom_range(0, 3))
          0: va[i*N +: N] = 32'h7FFFFFFF;
          1: va[i*N +: N] = 32'h80000000;
          default: va[i*N +: N] = $urandom;
        endcase
        vb[i*N +: N] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      end
      run_op("rand", 2'($urandom), 2'($urandom), va, vb, $urandom, $urandom,
             5'($urandom), $urandom_range(0, 3));
    end

    // Reset in RUN with valid_i held high
    op_type_i = 2'b01; valid_i = 1'b1; a3_i = 5'd17;
    tick();
    tick();
    chk("rst_run.busy_before", busy_o, 1'b1);
    RST = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_v = '0; exp_s = '0; exp_f = 2'b00; exp_a3 = '0; v_known = 1'b1;
    chk("rst_run.valid", valid_o, 1'b0);
    chk("rst_run.busy", busy_o, 1'b0);
    chk_outputs("rst_run");
    tick();
    chk("rst_run.no_accept", busy_o, 1'b0);
    valid_i = 1'b0;
    RST = 1'b1;
    tick();
    chk("rst_run.ready", ready_o, 1'b1);
    chk("rst_run.idle", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
